// File: rtl/rv_pkg.sv
// Shared definitions for the fetch front end: data width, the bubble instruction,
// the fetch FSM state type and the {pc, ins} packet carried from memory to decode.
package rv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INS = 32'h0000_0013;

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ins;
    } fetch_pkt_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding buffer for a fetched packet that arrives while decode is stalled.
module if_skid_buf
    import rv_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  fetch_pkt_t push_pkt,
    output logic       full,
    output fetch_pkt_t pkt
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pkt <= push_pkt;
        end
    end

    // The fetch FSM stops requesting while this entry is occupied, so it can never overflow.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, single-outstanding fetch FSM, output register
// toward decode with a one-entry skid buffer, and flush/redirect from the branch unit.
module if_stage
    import rv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            ins_valid,
    output logic [XLEN-1:0] ins_pc,
    output logic [XLEN-1:0] ins_code
);

    fetch_state_t    state;
    fetch_state_t    next_state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_pc;
    logic            issue;
    logic            resp;
    logic            transfer;
    logic            out_free;
    logic            skid_full;
    logic            skid_push;
    logic            skid_pop;
    fetch_pkt_t      skid_pkt;
    fetch_pkt_t      rsp_pkt;
    logic            orphan_rsp;

    assign issue     = imem_req && imem_gnt;
    assign resp      = (state == WAIT) && imem_rvalid && !redirect_valid;
    assign transfer  = ins_valid && id_ready && !redirect_valid;
    assign out_free  = !ins_valid || id_ready;
    assign skid_push = resp && !out_free;
    assign skid_pop  = transfer && skid_full;
    assign rsp_pkt   = '{pc: req_pc, ins: imem_rdata};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REQ;
        end else begin
            state <= next_state;
        end
    end

    // A redirect goes to DROP only if some fetch will still be in flight after this edge.
    always_comb begin
        next_state = state;
        if (redirect_valid) begin
            if (issue || ((state != REQ) && !imem_rvalid)) begin
                next_state = DROP;
            end else begin
                next_state = REQ;
            end
        end else begin
            case (state)
                REQ:     if (issue) next_state = WAIT;
                WAIT:    if (imem_rvalid) next_state = REQ;
                DROP:    if (imem_rvalid) next_state = REQ;
                default: next_state = REQ;
            endcase
        end
    end

    always_comb begin
        imem_req  = !rst && (state == REQ) && !skid_full;
        imem_addr = pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= redirect_pc & ~XLEN'(3);
        end else if (issue) begin
            pc <= pc + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (issue) begin
            req_pc <= pc;
        end
    end

    // Output register: new response when free/draining, else refill from the skid entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            ins_valid <= 1'b0;
            ins_pc    <= '0;
            ins_code  <= NOP_INS;
        end else if (redirect_valid) begin
            ins_valid <= 1'b0;
            ins_code  <= NOP_INS;
        end else if (resp && out_free) begin
            ins_valid <= 1'b1;
            ins_pc    <= rsp_pkt.pc;
            ins_code  <= rsp_pkt.ins;
        end else if (skid_pop) begin
            ins_valid <= 1'b1;
            ins_pc    <= skid_pkt.pc;
            ins_code  <= skid_pkt.ins;
        end else if (transfer) begin
            ins_valid <= 1'b0;
            ins_code  <= NOP_INS;
        end
    end

    if_skid_buf u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (skid_push),
        .pop      (skid_pop),
        .flush    (redirect_valid),
        .push_pkt (rsp_pkt),
        .full     (skid_full),
        .pkt      (skid_pkt)
    );

    // Remembers a fetch abandoned by reset so its late response is not flagged as a protocol error.
    always_ff @(posedge clk) begin
        if (rst) begin
            orphan_rsp <= orphan_rsp || (state != REQ);
        end else if (imem_rvalid) begin
            orphan_rsp <= 1'b0;
        end
    end

    a_addr_aligned: assert property (@(posedge clk) disable iff (rst)
        imem_addr[1:0] == 2'b00);

    a_out_stable: assert property (@(posedge clk) disable iff (rst)
        (ins_valid && !id_ready && !redirect_valid) |=> ($stable(ins_pc) && $stable(ins_code)));

    a_one_outstanding: assert property (@(posedge clk) disable iff (rst)
        (state != REQ) |-> !imem_req);

    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> ((state != REQ) || orphan_rsp));

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a small in-order memory responder plus a linear
// cycle-by-cycle script with hand-computed expectations.
module tb_if_stage;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready = 1'b1;
    logic        ins_valid;
    logic [31:0] ins_pc;
    logic [31:0] ins_code;

    int checks = 0;
    int errors = 0;

    logic        rst_cmd = 1'b1;
    bit          gnt_en = 1'b1;
    int          lat = 1;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    int          wait_cnt = 0;

    if_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .ins_valid      (ins_valid),
        .ins_pc         (ins_pc),
        .ins_code       (ins_code)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Memory responder: one outstanding fetch, data returned lat cycles after grant.
    task automatic drive_mem();
        if (imem_rvalid) pend = 1'b0;
        imem_rvalid = 1'b0;
        if (pend) begin
            if (wait_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(pend_addr);
            end else begin
                wait_cnt--;
            end
        end
        imem_gnt = gnt_en && imem_req && !pend;
        if (imem_gnt) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            wait_cnt  = lat - 1;
        end
    endtask

    task automatic apply_stimulus();
        @(posedge clk);
        #1;
        rst = rst_cmd;
        #1;
        drive_mem();
    endtask

    initial begin
        $display("[TB] if_stage directed test start");

        apply_stimulus();
        apply_stimulus();
        check_output("rst_req",   {31'd0, imem_req},  32'd0);
        check_output("rst_valid", {31'd0, ins_valid}, 32'd0);
        check_output("rst_code",  ins_code,           32'h0000_0013);
        check_output("rst_pc",    ins_pc,             32'h0000_0000);
        rst_cmd = 1'b0;

        // Zero-wait memory streaming
        apply_stimulus();
        check_output("c0_req",  {31'd0, imem_req}, 32'd1);
        check_output("c0_addr", imem_addr,         32'h0000_0000);
        apply_stimulus();
        check_output("c1_valid", {31'd0, ins_valid}, 32'd0);
        check_output("c1_req",   {31'd0, imem_req},  32'd0);
        apply_stimulus();
        check_output("c2_valid", {31'd0, ins_valid}, 32'd1);
        check_output("c2_pc",    ins_pc,             32'h0000_0000);
        check_output("c2_code",  ins_code,           32'hC0DE_0000);
        check_output("c2_addr",  imem_addr,          32'h0000_0004);
        apply_stimulus();
        check_output("c3_valid", {31'd0, ins_valid}, 32'd0);
        check_output("c3_code",  ins_code,           32'h0000_0013);
        apply_stimulus();
        check_output("c4_pc",   ins_pc,   32'h0000_0004);
        check_output("c4_code", ins_code, 32'hC0DE_0004);
        apply_stimulus();
        apply_stimulus();
        check_output("c6_valid", {31'd0, ins_valid}, 32'd1);
        check_output("c6_pc",    ins_pc,             32'h0000_0008);
        check_output("c6_addr",  imem_addr,          32'h0000_000C);

        // Decode stall: output holds, next word parks in the skid buffer
        id_ready = 1'b0;
        apply_stimulus();
        check_output("c7_pc",  ins_pc,            32'h0000_0008);
        check_output("c7_req", {31'd0, imem_req}, 32'd0);
        apply_stimulus();
        check_output("c8_req",   {31'd0, imem_req},  32'd0);
        check_output("c8_valid", {31'd0, ins_valid}, 32'd1);
        apply_stimulus();
        apply_stimulus();
        apply_stimulus();
        check_output("c11_pc",   ins_pc,            32'h0000_0008);
        check_output("c11_code", ins_code,          32'hC0DE_0008);
        check_output("c11_req",  {31'd0, imem_req}, 32'd0);
        apply_stimulus();
        id_ready = 1'b1;
        check_output("c12_pc",  ins_pc,            32'h0000_0008);
        check_output("c12_req", {31'd0, imem_req}, 32'd0);
        apply_stimulus();
        check_output("c13_valid", {31'd0, ins_valid}, 32'd1);
        check_output("c13_pc",    ins_pc,             32'h0000_000C);
        check_output("c13_code",  ins_code,           32'hC0DE_000C);
        check_output("c13_addr",  imem_addr,          32'h0000_0010);
        check_output("c13_req",   {31'd0, imem_req},  32'd1);
        apply_stimulus();
        check_output("c14_valid", {31'd0, ins_valid}, 32'd0);
        lat = 3;
        apply_stimulus();
        check_output("c15_pc",   ins_pc,    32'h0000_0010);
        check_output("c15_addr", imem_addr, 32'h0000_0014);

        // Redirect while waiting on a slow response
        apply_stimulus();
        check_output("c16_req", {31'd0, imem_req}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        apply_stimulus();
        redirect_valid = 1'b0;
        check_output("c17_req",   {31'd0, imem_req},  32'd0);
        check_output("c17_valid", {31'd0, ins_valid}, 32'd0);
        apply_stimulus();
        check_output("c18_req", {31'd0, imem_req}, 32'd0);
        apply_stimulus();
        check_output("c19_req",   {31'd0, imem_req},  32'd1);
        check_output("c19_addr",  imem_addr,          32'h0000_0100);
        check_output("c19_valid", {31'd0, ins_valid}, 32'd0);
        apply_stimulus();
        apply_stimulus();
        apply_stimulus();
        check_output("c22_valid", {31'd0, ins_valid}, 32'd0);
        lat = 1;
        apply_stimulus();
        check_output("c23_valid", {31'd0, ins_valid}, 32'd1);
        check_output("c23_pc",    ins_pc,             32'h0000_0100);
        check_output("c23_code",  ins_code,           32'hC0DE_0100);
        check_output("c23_addr",  imem_addr,          32'h0000_0104);

        // Redirect in the grant cycle with a word pending at decode
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        id_ready       = 1'b0;
        apply_stimulus();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        check_output("c24_valid", {31'd0, ins_valid}, 32'd0);
        check_output("c24_code",  ins_code,           32'h0000_0013);
        check_output("c24_req",   {31'd0, imem_req},  32'd0);
        apply_stimulus();
        check_output("c25_req",  {31'd0, imem_req}, 32'd1);
        check_output("c25_addr", imem_addr,         32'h0000_0200);
        apply_stimulus();
        apply_stimulus();
        check_output("c27_pc",   ins_pc,   32'h0000_0200);
        check_output("c27_code", ins_code, 32'hC0DE_0200);

        // Redirect to the top word (low bits masked), then wrap to zero
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        apply_stimulus();
        redirect_valid = 1'b0;
        check_output("c28_req", {31'd0, imem_req}, 32'd0);
        apply_stimulus();
        check_output("c29_addr", imem_addr, 32'hFFFF_FFFC);
        apply_stimulus();
        lat = 3;
        apply_stimulus();
        check_output("c31_addr",  imem_addr,          32'h0000_0000);
        check_output("c31_valid", {31'd0, ins_valid}, 32'd1);
        check_output("c31_pc",    ins_pc,             32'hFFFF_FFFC);
        check_output("c31_code",  ins_code,           32'h3F21_FFFC);

        // Reset while a fetch is outstanding; its late response must be ignored
        rst_cmd = 1'b1;
        apply_stimulus();
        check_output("c32_req", {31'd0, imem_req}, 32'd0);
        rst_cmd = 1'b0;
        gnt_en  = 1'b0;
        apply_stimulus();
        check_output("c33_req",   {31'd0, imem_req},  32'd1);
        check_output("c33_addr",  imem_addr,          32'h0000_0000);
        check_output("c33_valid", {31'd0, ins_valid}, 32'd0);
        check_output("c33_code",  ins_code,           32'h0000_0013);
        apply_stimulus();
        check_output("c34_rvalid", {31'd0, imem_rvalid}, 32'd1);
        gnt_en = 1'b1;
        lat    = 1;
        apply_stimulus();
        check_output("c35_valid", {31'd0, ins_valid}, 32'd0);
        check_output("c35_code",  ins_code,           32'h0000_0013);
        apply_stimulus();
        apply_stimulus();
        check_output("c37_valid", {31'd0, ins_valid}, 32'd1);
        check_output("c37_pc",    ins_pc,             32'h0000_0000);
        check_output("c37_code",  ins_code,           32'hC0DE_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
